// File: rtl/move_request_gen_pkg.sv
// ---------------------------------------------------------------------------
// move_request_gen_pkg
//   Shared definitions for the move request generator:
//     - 4-bit one-hot direction codes used for the held move and the strobes
//       (bit 0 = up, bit 1 = down, bit 2 = left, bit 3 = right)
//     - encoding of the capture FSM (EMPTY / HELD)
//     - pick_winner(): fixed-priority selection up > down > left > right
// ---------------------------------------------------------------------------
package move_request_gen_pkg;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    // Returns the one-hot code of the highest-priority pending event,
    // or DIR_NONE when no event is present.
    function automatic logic [3:0] pick_winner(input logic [3:0] ev);
        logic [3:0] win;
        win = DIR_NONE;
        if (ev[0]) begin
            win = DIR_UP;
        end else if (ev[1]) begin
            win = DIR_DOWN;
        end else if (ev[2]) begin
            win = DIR_LEFT;
        end else if (ev[3]) begin
            win = DIR_RIGHT;
        end
        return win;
    endfunction

endpackage

// File: rtl/move_request_gen_if.sv
// ---------------------------------------------------------------------------
// move_request_gen_if
//   Handshake between the move request generator and the game FSM.
//     game_ready : game FSM is waiting and can accept a move
//     up/down/left/right : one-cycle move strobes (at most one high)
//     pending    : a captured move is waiting to be issued
//   dropped    : one-cycle pulse when a press event was discarded
//   Modports:
//     master : the move request generator (drives strobes/status)
//     slave  : the game FSM side (drives game_ready)
// ---------------------------------------------------------------------------
interface move_request_gen_if;

    logic game_ready;
    logic up;
    logic down;
    logic left;
    logic right;
    logic pending;
    logic dropped;

    modport master (
        input  game_ready,
        output up,
        output down,
        output left,
        output right,
        output pending,
        output dropped
    );

    modport slave (
        output game_ready,
        input  up,
        input  down,
        input  left,
        input  right,
        input  pending,
        input  dropped
    );

endinterface

// File: rtl/move_request_gen_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Per-button conditioning: 2-flop synchronizer, counter-based debouncer and
//   rising-edge detector.
//   Parameters:
//     DB_CYCLES : stability window in Clk cycles (must be >= 2)
//   Ports:
//     Clk     : system clock, rising edge
//     Reset   : asynchronous, active-high
//     btn_raw : raw asynchronous, bouncing button (active-high)
//     press   : registered one-cycle pulse on a debounced 0->1 transition
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned     CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // The counter only advances while the synchronized input disagrees with
    // the debounced level; reaching CNT_MAX flips the level and restarts, so
    // it never wraps. The press pulse is registered on the same edge that
    // flips the level, and only for a 0->1 flip.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= ~level;
                cnt   <= '0;
                press <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/move_request_gen.sv
// ---------------------------------------------------------------------------
// move_request_gen
//   Turns four raw push-buttons into single move strobes for the game FSM.
//   Each button is synchronized, debounced and edge-detected; simultaneous
//   presses are resolved up > down > left > right. A single move is held in
//   a one-hot register until the game FSM reports ready, then issued as a
//   registered one-cycle strobe. Presses that cannot be captured pulse
//   dropped (one pulse per cycle at most).
//   Parameters:
//     DB_CYCLES : debounce stability window in Clk cycles (>= 2)
//   Ports:
//     Clk                    : system clock, rising edge
//     Reset                  : asynchronous, active-high
//     BtnU, BtnD, BtnL, BtnR : raw bouncing buttons, active-high
//     mv (master)            : game_ready in; up/down/left/right, pending,
//                              dropped out
// ---------------------------------------------------------------------------
module move_request_gen
    import move_request_gen_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               BtnU,
    input  logic               BtnD,
    input  logic               BtnL,
    input  logic               BtnR,
    move_request_gen_if.master mv
);

    logic [3:0] ev;
    logic [3:0] winner;
    logic       any_ev;
    logic       multi_ev;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] move_q;
    logic [3:0] move_d;
    logic [3:0] strobe_q;
    logic [3:0] strobe_d;
    logic       drop_q;
    logic       drop_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .Clk     (Clk),
        .Reset   (Reset),
        .btn_raw (BtnU),
        .press   (ev[0])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .Clk     (Clk),
        .Reset   (Reset),
        .btn_raw (BtnD),
        .press   (ev[1])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .Clk     (Clk),
        .Reset   (Reset),
        .btn_raw (BtnL),
        .press   (ev[2])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .Clk     (Clk),
        .Reset   (Reset),
        .btn_raw (BtnR),
        .press   (ev[3])
    );

    always_comb begin
        winner   = pick_winner(ev);
        any_ev   = |ev;
        multi_ev = |(ev & ~winner);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= EMPTY;
            move_q   <= '0;
            strobe_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            move_q   <= move_d;
            strobe_q <= strobe_d;
            drop_q   <= drop_d;
        end
    end

    // Issuing the held move and capturing a fresh event can happen on the
    // same edge: the strobe takes the old move while the register reloads,
    // so the state stays HELD and the new press is not counted as dropped.
    always_comb begin
        state_d  = state_q;
        move_d   = move_q;
        strobe_d = '0;
        drop_d   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (any_ev) begin
                    state_d = HELD;
                    move_d  = winner;
                    drop_d  = multi_ev;
                end
            end
            HELD: begin
                if (mv.game_ready) begin
                    strobe_d = move_q;
                    if (any_ev) begin
                        move_d = winner;
                        drop_d = multi_ev;
                    end else begin
                        state_d = EMPTY;
                        move_d  = '0;
                    end
                end else begin
                    drop_d = any_ev;
                end
            end
            default: begin
                state_d = EMPTY;
                move_d  = '0;
            end
        endcase
    end

    assign mv.up      = strobe_q[0];
    assign mv.down    = strobe_q[1];
    assign mv.left    = strobe_q[2];
    assign mv.right   = strobe_q[3];
    assign mv.pending = (state_q == HELD);
    assign mv.dropped = drop_q;

endmodule

// File: tb/tb_move_request_gen.sv
`timescale 1ns/1ps
module tb_move_request_gen;

    localparam int unsigned DB = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    logic BtnU  = 1'b0;
    logic BtnD  = 1'b0;
    logic BtnL  = 1'b0;
    logic BtnR  = 1'b0;
    logic game_ready = 1'b0;

    move_request_gen_if mv ();
    assign mv.game_ready = game_ready;

    move_request_gen #(.DB_CYCLES(DB)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .BtnU  (BtnU),
        .BtnD  (BtnD),
        .BtnL  (BtnL),
        .BtnR  (BtnR),
        .mv    (mv)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. A button's debounced level flips once the last DB
    // synchronized samples taken since the previous flip all disagree with
    // it; a 0->1 flip is a press the capture stage sees one edge later.
    // The capture stage is a one-entry mailbox.
    // ------------------------------------------------------------------
    logic [3:0]  rawq[$];
    logic [3:0]  sq[$];
    int unsigned since[4];
    logic [3:0]  lvl;
    logic [3:0]  ev_vis;
    logic [3:0]  held;
    logic [3:0]  m_strobe;
    logic        m_drop;

    task automatic model_step();
        logic [3:0] sv;
        logic [3:0] win;
        logic [3:0] new_ev;
        int         n;
        bit         all_diff;
        sv  = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 4'b0000;
        n   = $countones(ev_vis);
        win = ev_vis & (~ev_vis + 4'd1);
        m_strobe = 4'b0000;
        m_drop   = 1'b0;
        if (held != 4'b0000 && game_ready) begin
            m_strobe = held;
            held     = 4'b0000;
            if (n > 0) begin
                held   = win;
                m_drop = (n > 1);
            end
        end else if (held != 4'b0000) begin
            m_drop = (n > 0);
        end else if (n > 0) begin
            held   = win;
            m_drop = (n > 1);
        end
        sq.push_back(sv);
        if (sq.size() > DB) void'(sq.pop_front());
        new_ev = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            since[b]++;
            if (since[b] >= DB) begin
                all_diff = 1'b1;
                for (int i = 0; i < DB; i++)
                    if (sq[sq.size()-1-i][b] == lvl[b]) all_diff = 1'b0;
                if (all_diff) begin
                    lvl[b]   = ~lvl[b];
                    since[b] = 0;
                    if (lvl[b]) new_ev[b] = 1'b1;
                end
            end
        end
        ev_vis = new_ev;
        rawq.push_back({BtnR, BtnL, BtnD, BtnU});
        if (rawq.size() > 4) void'(rawq.pop_front());
    endtask

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rawq.delete();
            sq.delete();
            for (int b = 0; b < 4; b++) since[b] = 0;
            lvl      = 4'b0000;
            ev_vis   = 4'b0000;
            held     = 4'b0000;
            m_strobe = 4'b0000;
            m_drop   = 1'b0;
        end else begin
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare and pulse bookkeeping
    // ------------------------------------------------------------------
    int d_cnt[4];
    int m_cnt[4];
    int d_last[4];
    int d_drop;
    int m_dropc;

    task automatic clear_counts();
        for (int b = 0; b < 4; b++) begin
            d_cnt[b]  = 0;
            m_cnt[b]  = 0;
            d_last[b] = 0;
        end
        d_drop  = 0;
        m_dropc = 0;
    endtask

    always @(negedge Clk) begin
        logic [3:0] d_str;
        cyc++;
        d_str = {mv.right, mv.left, mv.down, mv.up};
        check("strobes", d_str, m_strobe);
        check("pending", mv.pending, (held != 4'b0000));
        check("dropped", mv.dropped, m_drop);
        check("onehot0", ($countones(d_str) <= 1), 1);
        for (int b = 0; b < 4; b++) begin
            if (d_str[b]) begin
                d_cnt[b]++;
                d_last[b] = cyc;
            end
            if (m_strobe[b]) m_cnt[b]++;
        end
        if (mv.dropped) d_drop++;
        if (m_drop) m_dropc++;
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic release_all(input int idle);
        BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
        repeat (idle) step();
    endtask

    initial begin
        int first_pend;
        int first_dn;
        int rate;

        clear_counts();
        #1 Reset = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
        step();
        check("rst_pending", mv.pending, 0);
        check("rst_strobes", {mv.right, mv.left, mv.down, mv.up}, 0);
        check("rst_dropped", mv.dropped, 0);

        // Bouncing up press, ready high
        clear_counts();
        game_ready = 1'b1;
        BtnU = 1'b1; step();
        BtnU = 1'b0; step();
        BtnU = 1'b1;
        repeat (10) step();
        release_all(12);
        check("s1_up_dut", d_cnt[0], 1);
        check("s1_up_model", m_cnt[0], 1);
        check("s1_other", d_cnt[1] + d_cnt[2] + d_cnt[3], 0);
        check("s1_drop", d_drop, 0);

        // Left and right together
        clear_counts();
        BtnL = 1'b1; BtnR = 1'b1;
        repeat (12) step();
        release_all(12);
        check("s2_left_dut", d_cnt[2], 1);
        check("s2_left_model", m_cnt[2], 1);
        check("s2_right", d_cnt[3], 0);
        check("s2_drop_dut", d_drop, 1);
        check("s2_drop_model", m_dropc, 1);

        // Held move while not ready, second press dropped
        clear_counts();
        game_ready = 1'b0;
        BtnD = 1'b1;
        repeat (10) step();
        BtnR = 1'b1;
        repeat (10) step();
        check("s3_pending_hi", mv.pending, 1);
        check("s3_drop", d_drop, 1);
        check("s3_no_strobe", d_cnt[0] + d_cnt[1] + d_cnt[2] + d_cnt[3], 0);
        game_ready = 1'b1;
        repeat (4) step();
        check("s3_down", d_cnt[1], 1);
        check("s3_right", d_cnt[3], 0);
        check("s3_pending_lo", mv.pending, 0);
        release_all(12);

        // Issue and new capture on the same edge
        game_ready = 1'b0;
        BtnD = 1'b1;
        repeat (10) step();
        clear_counts();
        BtnU = 1'b1;
        repeat (6) step();
        game_ready = 1'b1;
        repeat (5) step();
        check("s4_down", d_cnt[1], 1);
        check("s4_up", d_cnt[0], 1);
        check("s4_gap", d_last[0] - d_last[1], 1);
        check("s4_drop", d_drop, 0);
        check("s4_pending_lo", mv.pending, 0);
        release_all(12);

        // Reset while HELD, button still held afterwards
        game_ready = 1'b0;
        BtnD = 1'b1;
        repeat (10) step();
        check("s5_pending_hi", mv.pending, 1);
        Reset = 1'b1;
        #1;
        check("s5_rst_pending", mv.pending, 0);
        check("s5_rst_strobes", {mv.right, mv.left, mv.down, mv.up}, 0);
        check("s5_rst_dropped", mv.dropped, 0);
        clear_counts();
        step();
        step();
        Reset = 1'b0;
        game_ready = 1'b1;
        first_pend = 0;
        first_dn   = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (mv.pending && first_pend == 0) first_pend = n;
            if (mv.down && first_dn == 0) first_dn = n;
        end
        check("s5_pend_latency", first_pend, 7);
        check("s5_down_latency", first_dn, 8);
        check("s5_down_count", d_cnt[1], 1);
        check("s5_drop", d_drop, 0);
        release_all(12);

        // Randomized bouncing, readiness and occasional reset
        for (int blk = 0; blk < 15; blk++) begin
            rate = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 10 : 30);
            for (int t = 0; t < 200; t++) begin
                if ($urandom_range(0, rate - 1) == 0) BtnU = ~BtnU;
                if ($urandom_range(0, rate - 1) == 0) BtnD = ~BtnD;
                if ($urandom_range(0, rate - 1) == 0) BtnL = ~BtnL;
                if ($urandom_range(0, rate - 1) == 0) BtnR = ~BtnR;
                if ($urandom_range(0, 5) == 0) game_ready = ~game_ready;
                Reset = ($urandom_range(0, 399) == 0);
                step();
            end
        end
        Reset = 1'b0;
        release_all(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/move_request_gen.md
MOVE_REQUEST_GEN -- requirements
Module: move_request_gen

Interface
REQ-001 Parameter DB_CYCLES, default 500000, sets the debounce stability window in Clk cycles (5 ms at 100 MHz) and SHALL be at least 2.
REQ-002 Clk  input  1  system clock; all state SHALL be updated on the rising edge.
REQ-003 Reset  input  1  reset, asynchronous, active-high.
REQ-004 BtnU, BtnD, BtnL, BtnR  input  1 each  raw, asynchronous, bouncing push-buttons; active-high.
REQ-005 game_ready  input  1  high while the game FSM is in WAIT and can accept a move.
REQ-006 up, down, left, right  output  1 each  move strobes to the game FSM; at most one SHALL be high in any cycle.
REQ-007 pending  output  1  high while a captured move awaits issue.
REQ-008 dropped  output  1  one-cycle pulse when a press event is discarded.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each button SHALL have a debounced level and a counter; the counter SHALL clear whenever the synchronized input equals the debounced level.
REQ-011 The counter SHALL increment while the synchronized input differs from the debounced level.
REQ-012 When the counter reaches DB_CYCLES-1 while still differing, the debounced level SHALL toggle and the counter SHALL clear.
REQ-013 The counter width SHALL be $clog2(DB_CYCLES) and it SHALL never wrap.
REQ-014 A press event SHALL be a single-cycle pulse on a debounced 0->1 transition; releases SHALL produce no event.
REQ-015 For simultaneous press events in one cycle, priority SHALL be up > down > left > right.
REQ-016 The winner of REQ-015 SHALL be captured; each loser SHALL be discarded and SHALL pulse dropped.
REQ-017 The FSM SHALL have two states, EMPTY and HELD, with EMPTY as the reset state.
REQ-018 EMPTY -> HELD on a press event; the one-hot move register SHALL load the winning direction.
REQ-019 HELD with game_ready=0: SHALL stay HELD, the move register SHALL be unchanged, and every new press event SHALL pulse dropped.
REQ-020 HELD with game_ready=1: the next cycle SHALL assert the matching strobe for exactly one cycle and clear the move register.
REQ-021 In the case of REQ-020, the FSM SHALL go to EMPTY, or stay HELD with the new move if a press event arrives in that same cycle; nothing is dropped in that case.
REQ-022 Strobes SHALL be registered.
REQ-023 Minimum latency SHALL be 2 cycles (event -> HELD -> strobe) with game_ready held high.
REQ-024 game_ready seen while EMPTY SHALL have no effect; strobes SHALL never assert without a held move.
REQ-025 pending SHALL equal (state == HELD).
REQ-026 dropped SHALL be registered and SHALL be one pulse per cycle regardless of how many events are discarded in that cycle.

Reset
REQ-027 Reset SHALL force, asynchronously: the FSM to EMPTY; move register, strobes, pending and dropped to 0; synchronizers, debounced levels and counters to 0.
REQ-028 A reset that arrives mid-debounce or while HELD SHALL discard the move with no strobe and no dropped pulse.
REQ-029 A button held through reset deassertion SHALL produce one press event after DB_CYCLES+2 cycles.

Structure
REQ-030 The shared package SHALL hold the 4-bit one-hot direction constants DIR_UP=0001, DIR_DOWN=0010, DIR_LEFT=0100, DIR_RIGHT=1000 and the FSM state encoding.
REQ-031 Per-button synchronize+debounce+edge logic SHALL be one sub-module, btn_debounce, instantiated four times.

Verification (DB_CYCLES=4)
REQ-032 Bench: BtnU bounces 1/0/1 at 1-cycle spacing, then holds high 10 cycles, with game_ready=1 -> exactly one up pulse, dropped never asserts.
REQ-033 Bench: BtnL and BtnR rise in the same cycle and are held -> one left strobe, one dropped pulse, no right strobe.
REQ-034 Bench: game_ready=0, press D, then press R -> pending=1, dropped pulses once; raise game_ready -> single down strobe, pending returns to 0.
REQ-035 Bench: game_ready=1 and the held move issues in the same cycle a new U event arrives -> down strobe, then up strobe 1 cycle later, no dropped.
REQ-036 Bench: Reset pulsed while HELD -> all outputs 0 immediately, no strobe afterward; a button still held after reset gives one event after 6 cycles.
